user_input_ctrl: RTL and testbench

USER_INPUT_CTRL -- requirements
Module: user_input_ctrl

---
 rtl/user_input_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_user_input_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : user_input_ctrl
// Description : Debounced push-button front end for two keys plus a
//               synchronized slide-switch bus.
//               Each accepted key press yields a one-clock pulse. The switch
//               bus is snapshotted on every pulse.
// Ports       : clk             - system clock
//               rstN            - asynchronous active-low reset
//               key_jump_stateN - raw push-button, low = pressed
//               key_jump_addrN  - raw push-button, low = pressed
//               sw              - raw slide switches [SW_WIDTH]
//               jump_state      - one-clock pulse on accepted jump_state press
//               jump_addr       - one-clock pulse on accepted jump_addr press
//               sw_value        - switch snapshot taken with each pulse
//               key_busy        - either key FSM away from IDLE
// Option      : define USER_INPUT_AUTO_REPEAT_EN to enable auto-repeat of
//               jump_addr while its key stays held.
// Revision    : 1.0 - initial release
// ============================================================================
module user_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 16,
  parameter int SW_WIDTH        = 18
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                key_jump_stateN,
  input  logic                key_jump_addrN,
  input  logic [SW_WIDTH-1:0] sw,
  output logic                jump_state,
  output logic                jump_addr,
  output logic [SW_WIDTH-1:0] sw_value,
  output logic                key_busy
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_FULL = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  // --------------------------------------------------------------------------
  // Two-flop synchronizers. Keys idle high (released), switches idle low.
  // Bit 0 = jump_state key, bit 1 = jump_addr key.
  // --------------------------------------------------------------------------
  logic [1:0]          key_raw_n;
  logic [1:0]          key_meta_q;
  logic [1:0]          key_sync_q;
  logic [SW_WIDTH-1:0] sw_meta_q;
  logic [SW_WIDTH-1:0] sw_sync_q;

  assign key_raw_n = {key_jump_addrN, key_jump_stateN};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      key_meta_q <= 2'b11;
      key_sync_q <= 2'b11;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      key_meta_q <= key_raw_n;
      key_sync_q <= key_meta_q;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Per-key debounce FSMs
  // --------------------------------------------------------------------------
  logic [1:0] press_vec;
  logic [1:0] busy_vec;
  logic       addr_rpt;

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_state_e       state_q;
    key_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_hit;
    logic             key_low;

    assign key_low = ~key_sync_q[i];

    // The pulse is decoded in the cycle whose closing edge commits the
    // PRESS_WAIT -> HELD move, so it appears DEBOUNCE_CYCLES+2 clocks after
    // the raw edge and sw_value (loaded on that edge) is valid one clock later.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_hit = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_low) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!key_low) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q >= DEB_LAST) begin
            state_d   = ST_HELD;
            cnt_d     = DEB_FULL;
            press_hit = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!key_low) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (key_low) begin
            state_d = ST_HELD;
            cnt_d   = DEB_FULL;
          end else if (cnt_q >= DEB_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press_vec[i] = press_hit;
    assign busy_vec[i]  = (state_q != ST_IDLE);

    if (i == 1) begin : g_addr_repeat
`ifdef USER_INPUT_AUTO_REPEAT_EN
      localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

      logic [CNT_W-1:0] rpt_q;
      logic [CNT_W-1:0] rpt_d;
      logic             stay_held;

      // Only count while the key remains held; any high sample (the move into
      // RELEASE_WAIT) clears the count so a return to HELD restarts the period.
      assign stay_held = (state_q == ST_HELD) && key_low;

      always_comb begin
        rpt_d    = '0;
        addr_rpt = 1'b0;
        if (stay_held) begin
          if (rpt_q >= RPT_LAST) begin
            addr_rpt = 1'b1;
            rpt_d    = '0;
          end else begin
            rpt_d = rpt_q + CNT_ONE;
          end
        end
      end

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          rpt_q <= '0;
        end else begin
          rpt_q <= rpt_d;
        end
      end
`else
      assign addr_rpt = 1'b0;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. jump_state wins a same-cycle collision; the addr pulse is dropped
  // while its FSM still advances normally.
  // --------------------------------------------------------------------------
  logic [SW_WIDTH-1:0] sw_value_q;
  logic [SW_WIDTH-1:0] sw_value_d;

  assign jump_state = press_vec[0];
  assign jump_addr  = (press_vec[1] | addr_rpt) & ~press_vec[0];
  assign key_busy   = |busy_vec;

  always_comb begin
    sw_value_d = sw_value_q;
    if (jump_state || jump_addr) begin
      sw_value_d = sw_sync_q;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sw_value_q <= '0;
    end else begin
      sw_value_q <= sw_value_d;
    end
  end

  assign sw_value = sw_value_q;

endmodule
`default_nettype wire

// File: tb/tb_user_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_input_ctrl
// Description : Self-checking bench for user_input_ctrl. Expected pulses are
//               queued when stimulus is applied and matched as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_input_ctrl;

  localparam int SW_WIDTH = 18;
  localparam int DEB      = 8;
  localparam int RPT      = 16;
  localparam int LAT      = DEB + 2;

  logic                clk             = 1'b0;
  logic                rstN            = 1'b1;
  logic                key_jump_stateN = 1'b1;
  logic                key_jump_addrN  = 1'b1;
  logic [SW_WIDTH-1:0] sw              = '0;
  logic                jump_state;
  logic                jump_addr;
  logic [SW_WIDTH-1:0] sw_value;
  logic                key_busy;

  user_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (RPT),
    .SW_WIDTH       (SW_WIDTH)
  ) dut (
    .clk            (clk),
    .rstN           (rstN),
    .key_jump_stateN(key_jump_stateN),
    .key_jump_addrN (key_jump_addrN),
    .sw             (sw),
    .jump_state     (jump_state),
    .jump_addr      (jump_addr),
    .sw_value       (sw_value),
    .key_busy       (key_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  cyc;
    bit                  is_addr;
    logic [SW_WIDTH-1:0] sw;
  } exp_t;

  exp_t                exp_q[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  cyc    = 0;
  bit                  sw_pend = 1'b0;
  logic [SW_WIDTH-1:0] sw_exp  = '0;

  // Scoreboard monitor: samples 1 time unit after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (sw_pend) begin
        checks++;
        if (sw_value !== sw_exp) begin
          errors++;
          $display("FAIL sw_capture cyc=%0d got=%h exp=%h", cyc, sw_value, sw_exp);
        end
        sw_pend = 1'b0;
      end
      if (jump_state === 1'b1 || jump_addr === 1'b1) begin
        checks++;
        if (jump_state === 1'b1 && jump_addr === 1'b1) begin
          errors++;
          $display("FAIL pulse_both cyc=%0d got=both exp=one", cyc);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected cyc=%0d got state=%b addr=%b exp=none",
                   cyc, jump_state, jump_addr);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.is_addr != jump_addr) begin
            errors++;
            $display("FAIL pulse_match got cyc=%0d addr=%b exp cyc=%0d addr=%b",
                     cyc, jump_addr, e.cyc, e.is_addr);
          end
          sw_pend = 1'b1;
          sw_exp  = e.sw;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input bit is_addr, input logic [SW_WIDTH-1:0] s);
    exp_t e;
    e.cyc     = c;
    e.is_addr = is_addr;
    e.sw      = s;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    sw = 18'h2AAAA;
    #2 rstN = 1'b0;
    tick(3);
    checks++;
    if (jump_state !== 1'b0) begin errors++; $display("FAIL reset_jump_state got=%b exp=0", jump_state); end
    checks++;
    if (jump_addr !== 1'b0) begin errors++; $display("FAIL reset_jump_addr got=%b exp=0", jump_addr); end
    checks++;
    if (key_busy !== 1'b0) begin errors++; $display("FAIL reset_key_busy got=%b exp=0", key_busy); end
    checks++;
    if (sw_value !== '0) begin errors++; $display("FAIL reset_sw_value got=%h exp=0", sw_value); end
    rstN = 1'b1;
    tick(5);
  endtask

  task automatic test_press();
    sw = 18'h00A5A;
    tick(2);
    key_jump_stateN = 1'b0;
    push_exp(cyc + LAT, 1'b0, 18'h00A5A);
    tick(20);
    checks++;
    if (key_busy !== 1'b1) begin errors++; $display("FAIL press_busy got=%b exp=1", key_busy); end
    sw = 18'h15555;
    tick(180);
    checks++;
    if (sw_value !== 18'h00A5A) begin errors++; $display("FAIL press_sw_hold got=%h exp=00a5a", sw_value); end
    key_jump_stateN = 1'b1;
    tick(20);
    checks++;
    if (key_busy !== 1'b0) begin errors++; $display("FAIL press_idle got=%b exp=0", key_busy); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL press_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_glitch();
    key_jump_addrN = 1'b0;
    tick(4);
    checks++;
    if (key_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got=%b exp=1", key_busy); end
    tick(1);
    key_jump_addrN = 1'b1;
    tick(20);
    checks++;
    if (key_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got=%b exp=0", key_busy); end
  endtask

  task automatic test_bounce();
    sw = 18'h3C3C3;
    tick(2);
    for (int k = 0; k < 10; k++) begin
      key_jump_stateN = (k % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    key_jump_stateN = 1'b0;
    push_exp(cyc + LAT, 1'b0, 18'h3C3C3);
    tick(25);
    key_jump_stateN = 1'b1;
    tick(20);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bounce_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_simultaneous();
    sw = 18'h01234;
    tick(2);
    key_jump_stateN = 1'b0;
    key_jump_addrN  = 1'b0;
    push_exp(cyc + LAT, 1'b0, 18'h01234);
    tick(15);
    checks++;
    if (key_busy !== 1'b1) begin errors++; $display("FAIL simul_busy got=%b exp=1", key_busy); end
    tick(5);
    key_jump_stateN = 1'b1;
    key_jump_addrN  = 1'b1;
    tick(20);
    checks++;
    if (key_busy !== 1'b0) begin errors++; $display("FAIL simul_idle got=%b exp=0", key_busy); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL simul_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    sw = 18'h00777;
    tick(2);
    key_jump_addrN = 1'b0;
    push_exp(cyc + LAT, 1'b1, 18'h00777);
    tick(20);
    key_jump_addrN = 1'b1;   // short release bounce: must not re-trigger
    tick(3);
    key_jump_addrN = 1'b0;
    tick(8);
    key_jump_addrN = 1'b1;
    tick(16);
    checks++;
    if (key_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", key_busy); end
    sw = 18'h2BEEF;
    tick(2);
    key_jump_addrN = 1'b0;
    push_exp(cyc + LAT, 1'b1, 18'h2BEEF);
    tick(14);
    key_jump_addrN = 1'b1;
    tick(16);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_addr_hold();
    int                  f;
    logic [SW_WIDTH-1:0] last_sw;
    sw = 18'h0000A;
    tick(2);
    key_jump_addrN = 1'b0;
    f = cyc;
    push_exp(f + LAT, 1'b1, 18'h0000A);
    last_sw = 18'h0000A;
`ifdef USER_INPUT_AUTO_REPEAT_EN
    push_exp(f + LAT + RPT,     1'b1, 18'h0000B);
    push_exp(f + LAT + 2 * RPT, 1'b1, 18'h0000C);
    push_exp(f + LAT + 3 * RPT, 1'b1, 18'h0000D);
    last_sw = 18'h0000D;
`endif
    tick(15);
    sw = 18'h0000B;
    tick(16);
    sw = 18'h0000C;
    tick(16);
    sw = 18'h0000D;
    tick(13);
    key_jump_addrN = 1'b1;
    tick(20);
    checks++;
    if (sw_value !== last_sw) begin errors++; $display("FAIL hold_sw_value got=%h exp=%h", sw_value, last_sw); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL hold_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    sw = 18'h0F0F0;
    tick(2);
    key_jump_stateN = 1'b0;
    tick(5);
    rstN = 1'b0;
    #1;
    checks++;
    if (key_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", key_busy); end
    checks++;
    if (sw_value !== '0) begin errors++; $display("FAIL rstmid_sw_value got=%h exp=0", sw_value); end
    checks++;
    if (jump_state !== 1'b0 || jump_addr !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pulses got=%b%b exp=00", jump_state, jump_addr);
    end
    tick(3);
    rstN = 1'b1;
    push_exp(cyc + LAT, 1'b0, 18'h0F0F0);
    tick(20);
    key_jump_stateN = 1'b1;
    tick(20);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_back_to_back();
    test_addr_hold();
    test_reset_mid();
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
